// File: rtl/featuremap_channel_reducer_pkg.sv
// Shared definitions for the feature-map channel reducer.
//   clog2       : ceiling log2, 0 for inputs of 0 or 1
//   acc_w       : adder-tree accumulator width for a lane width and lane count
//   latency     : input-handshake to valid_out latency in cycles
//   saturate    : clamp a wide signed value into a w-bit signed range
//   leaky_relu  : floor-shift negative values, pass non-negative values through
package featuremap_channel_reducer_pkg;

   function automatic int unsigned clog2(input int unsigned v);
      int unsigned r;
      r = 0;
      for (int unsigned i = 0; i < 32; i++) begin
         if ((64'd1 << i) < 64'(v)) r = i + 1;
      end
      return r;
   endfunction

   function automatic int unsigned acc_w(input int unsigned dw, input int unsigned nch);
      return dw + clog2(nch) + 1;
   endfunction

   function automatic int unsigned latency(input int unsigned nch);
      return clog2(nch) + 2;
   endfunction

   function automatic logic signed [63:0] saturate(input logic signed [63:0] v,
                                                   input int unsigned w);
      logic signed [63:0] hi;
      logic signed [63:0] lo;
      hi = (64'sd1 <<< (w - 1)) - 64'sd1;
      lo = -(64'sd1 <<< (w - 1));
      if (v > hi) return hi;
      if (v < lo) return lo;
      return v;
   endfunction

   function automatic logic signed [63:0] leaky_relu(input logic signed [63:0] v,
                                                     input int unsigned sh);
      return (v < 0) ? (v >>> sh) : v;
   endfunction

endpackage

// File: rtl/featuremap_channel_reducer_if.sv
// Stream bundle for the channel reducer.
//   data_in/valid_in/ready_out : packed per-channel partial results in
//   data_out/valid_out/ready_in: reduced output pixel out
//   last_out                   : data_out is the final pixel of a frame
//   frame_done                 : one-cycle pulse after the final pixel handshake
// slave is the reducer's view, master is the surrounding logic's view.
interface featuremap_channel_reducer_if
   import featuremap_channel_reducer_pkg::*;
#(
   parameter int unsigned NUM_CH     = 16,
   parameter int unsigned DATA_WIDTH = 16
);
   logic [NUM_CH*DATA_WIDTH-1:0] data_in;
   logic                         valid_in;
   logic                         ready_out;
   logic [DATA_WIDTH-1:0]        data_out;
   logic                         valid_out;
   logic                         ready_in;
   logic                         last_out;
   logic                         frame_done;

   modport slave (
      input  data_in, valid_in, ready_in,
      output ready_out, data_out, valid_out, last_out, frame_done
   );

   modport master (
      output data_in, valid_in, ready_in,
      input  ready_out, data_out, valid_out, last_out, frame_done
   );
endinterface

// File: rtl/featuremap_channel_reducer_adder_tree_stage.sv
// One registered row of the channel adder tree: N_OUT pair sums of W-bit
// signed operands. Operands are pre-widened, so the sums cannot overflow.
//   Clk/Rst : clock, synchronous active-low reset
//   en      : pipeline advance; row holds when low
//   valid_i/sum_i : incoming row (2*N_OUT entries) and its valid
//   valid_o/sum_o : registered row (N_OUT entries) and its valid
module adder_tree_stage
   import featuremap_channel_reducer_pkg::*;
#(
   parameter int unsigned N_OUT = 1,
   parameter int unsigned W     = 16
) (
   input  logic                 Clk,
   input  logic                 Rst,
   input  logic                 en,
   input  logic                 valid_i,
   input  logic [2*N_OUT*W-1:0] sum_i,
   output logic                 valid_o,
   output logic [N_OUT*W-1:0]   sum_o
);
   always_ff @(posedge Clk) begin
      if (!Rst) begin
         valid_o <= 1'b0;
         sum_o   <= '0;
      end else if (en) begin
         valid_o <= valid_i;
         for (int unsigned j = 0; j < N_OUT; j++) begin
            sum_o[j*W +: W] <= W'(signed'(sum_i[2*j*W +: W]) + signed'(sum_i[(2*j+1)*W +: W]));
         end
      end
   end
endmodule

// File: rtl/featuremap_channel_reducer.sv
// Reduces NUM_CH per-channel convolution partials to one output-map pixel:
// registered adder tree, bias + optional leaky ReLU + saturation stage, output
// register, and a frame pixel counter that tags the last pixel.
//   Clk/Rst : clock, synchronous active-low reset
//   io      : slave side of the stream bundle (input lanes, output pixel,
//             last_out, frame_done); ready_out = !(valid_out && !ready_in)
module featuremap_channel_reducer
   import featuremap_channel_reducer_pkg::*;
#(
   parameter int unsigned                  NUM_CH      = 16,
   parameter int unsigned                  DATA_WIDTH  = 16,
   parameter int unsigned                  FRAC_BITS   = 8,
   parameter int unsigned                  IMG_SIZE    = 208,
   parameter logic signed [DATA_WIDTH-1:0] BIAS        = '0,
   parameter bit                           ACT_EN      = 1'b1,
   parameter int unsigned                  LEAKY_SHIFT = 3
) (
   input  logic                        Clk,
   input  logic                        Rst,
   featuremap_channel_reducer_if.slave io
);
   localparam int unsigned S     = clog2(NUM_CH);
   localparam int unsigned P     = 32'd1 << S;
   localparam int unsigned ACC_W = acc_w(DATA_WIDTH, NUM_CH);
   localparam int unsigned PIX   = IMG_SIZE * IMG_SIZE;
   localparam int unsigned CNT_W = (clog2(PIX) == 0) ? 1 : clog2(PIX);

   if (NUM_CH == 0 || FRAC_BITS >= DATA_WIDTH) begin : g_bad_params
      $error("featuremap_channel_reducer: invalid NUM_CH or FRAC_BITS");
   end

   // Single global stall: everything advances together, bubbles included.
   logic en;
   assign en           = !(io.valid_out && !io.ready_in);
   assign io.ready_out = en;

   // Level 0 is the sign-extended, zero-padded lane vector; level i is the
   // output of tree row i. g_lvl[S] holds the single reduced sum.
   genvar i, k;
   for (i = 0; i <= S; i++) begin : g_lvl
      logic [(P>>i)*ACC_W-1:0] sum;
      logic                    valid;
      if (i == 0) begin : g_in
         for (k = 0; k < P; k++) begin : g_lane
            if (k < NUM_CH) begin : g_used
               assign sum[k*ACC_W +: ACC_W] = ACC_W'(signed'(io.data_in[k*DATA_WIDTH +: DATA_WIDTH]));
            end else begin : g_pad
               assign sum[k*ACC_W +: ACC_W] = '0;
            end
         end
         assign valid = io.valid_in;
      end else begin : g_row
         adder_tree_stage #(
            .N_OUT (P >> i),
            .W     (ACC_W)
         ) u_stage (
            .Clk     (Clk),
            .Rst     (Rst),
            .en      (en),
            .valid_i (g_lvl[i-1].valid),
            .sum_i   (g_lvl[i-1].sum),
            .valid_o (valid),
            .sum_o   (sum)
         );
      end
   end

   logic signed [63:0]    post_sum;
   logic [DATA_WIDTH-1:0] post_d;
   always_comb begin
      post_sum = 64'(signed'(g_lvl[S].sum)) + 64'(BIAS);
      if (ACT_EN) post_sum = leaky_relu(post_sum, LEAKY_SHIFT);
      post_d = DATA_WIDTH'(saturate(post_sum, DATA_WIDTH));
   end

   logic                  post_valid;
   logic [DATA_WIDTH-1:0] post_data;
   always_ff @(posedge Clk) begin
      if (!Rst) begin
         post_valid   <= 1'b0;
         post_data    <= '0;
         io.valid_out <= 1'b0;
         io.data_out  <= '0;
      end else if (en) begin
         post_valid   <= g_lvl[S].valid;
         post_data    <= post_d;
         io.valid_out <= post_valid;
         io.data_out  <= post_data;
      end
   end

   logic [CNT_W-1:0] pix_count;
   logic             out_hs;
   logic             at_last;
   assign out_hs      = io.valid_out && io.ready_in;
   assign at_last     = (pix_count == CNT_W'(PIX - 1));
   assign io.last_out = io.valid_out && at_last;

   always_ff @(posedge Clk) begin
      if (!Rst) begin
         pix_count     <= '0;
         io.frame_done <= 1'b0;
      end else begin
         io.frame_done <= out_hs && at_last;
         if (out_hs) pix_count <= at_last ? '0 : pix_count + CNT_W'(1);
      end
   end
endmodule

// File: tb/tb_featuremap_channel_reducer.sv
module tb_featuremap_channel_reducer;
   import featuremap_channel_reducer_pkg::*;

   localparam int unsigned ND = 5;   // 0 default, 1 linear, 2 bias, 3 three-lane, 4 4x4 frame
   localparam int unsigned DW = 16;
   localparam int unsigned NCH  [ND] = '{16, 16, 16, 3, 16};
   localparam int          BIASV[ND] = '{0, 0, 256, 0, 0};
   localparam bit          ACTV [ND] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b1};
   localparam int unsigned LAT  [ND] = '{6, 6, 6, 4, 6};
   localparam int unsigned FPIX [ND] = '{43264, 43264, 43264, 43264, 16};

   logic Clk = 1'b0;
   logic Rst;
   always #5 Clk = ~Clk;

   logic [16*DW-1:0] din;
   logic             vin;
   logic             rin;

   featuremap_channel_reducer_if #(.NUM_CH(16), .DATA_WIDTH(DW)) if_def ();
   featuremap_channel_reducer_if #(.NUM_CH(16), .DATA_WIDTH(DW)) if_lin ();
   featuremap_channel_reducer_if #(.NUM_CH(16), .DATA_WIDTH(DW)) if_bias ();
   featuremap_channel_reducer_if #(.NUM_CH(3),  .DATA_WIDTH(DW)) if_ch3 ();
   featuremap_channel_reducer_if #(.NUM_CH(16), .DATA_WIDTH(DW)) if_img4 ();

   assign if_def.data_in  = din;  assign if_def.valid_in  = vin;  assign if_def.ready_in  = rin;
   assign if_lin.data_in  = din;  assign if_lin.valid_in  = vin;  assign if_lin.ready_in  = rin;
   assign if_bias.data_in = din;  assign if_bias.valid_in = vin;  assign if_bias.ready_in = rin;
   assign if_ch3.data_in  = din[3*DW-1:0]; assign if_ch3.valid_in = vin; assign if_ch3.ready_in = rin;
   assign if_img4.data_in = din;  assign if_img4.valid_in = vin;  assign if_img4.ready_in = rin;

   featuremap_channel_reducer #(.NUM_CH(16), .DATA_WIDTH(DW), .IMG_SIZE(208), .BIAS(16'sh0000), .ACT_EN(1'b1))
      u_def (.Clk(Clk), .Rst(Rst), .io(if_def.slave));
   featuremap_channel_reducer #(.NUM_CH(16), .DATA_WIDTH(DW), .IMG_SIZE(208), .BIAS(16'sh0000), .ACT_EN(1'b0))
      u_lin (.Clk(Clk), .Rst(Rst), .io(if_lin.slave));
   featuremap_channel_reducer #(.NUM_CH(16), .DATA_WIDTH(DW), .IMG_SIZE(208), .BIAS(16'sh0100), .ACT_EN(1'b1))
      u_bias (.Clk(Clk), .Rst(Rst), .io(if_bias.slave));
   featuremap_channel_reducer #(.NUM_CH(3), .DATA_WIDTH(DW), .IMG_SIZE(208), .BIAS(16'sh0000), .ACT_EN(1'b1))
      u_ch3 (.Clk(Clk), .Rst(Rst), .io(if_ch3.slave));
   featuremap_channel_reducer #(.NUM_CH(16), .DATA_WIDTH(DW), .IMG_SIZE(4), .BIAS(16'sh0000), .ACT_EN(1'b1))
      u_img4 (.Clk(Clk), .Rst(Rst), .io(if_img4.slave));

   logic [DW-1:0] dout [ND];
   logic          vout [ND];
   logic          rout [ND];
   logic          lout [ND];
   logic          fdone[ND];
   assign dout[0] = if_def.data_out;  assign vout[0] = if_def.valid_out;  assign rout[0] = if_def.ready_out;
   assign dout[1] = if_lin.data_out;  assign vout[1] = if_lin.valid_out;  assign rout[1] = if_lin.ready_out;
   assign dout[2] = if_bias.data_out; assign vout[2] = if_bias.valid_out; assign rout[2] = if_bias.ready_out;
   assign dout[3] = if_ch3.data_out;  assign vout[3] = if_ch3.valid_out;  assign rout[3] = if_ch3.ready_out;
   assign dout[4] = if_img4.data_out; assign vout[4] = if_img4.valid_out; assign rout[4] = if_img4.ready_out;
   assign lout[0] = if_def.last_out;  assign fdone[0] = if_def.frame_done;
   assign lout[1] = if_lin.last_out;  assign fdone[1] = if_lin.frame_done;
   assign lout[2] = if_bias.last_out; assign fdone[2] = if_bias.frame_done;
   assign lout[3] = if_ch3.last_out;  assign fdone[3] = if_ch3.frame_done;
   assign lout[4] = if_img4.last_out; assign fdone[4] = if_img4.frame_done;

   int unsigned applied     = 0;
   int unsigned miscompares = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      applied++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   // Reference: integer sum of the used lanes, plus bias, floor-divide by 8
   // when negative and activation is on, then clamp to 16-bit signed.
   function automatic logic [DW-1:0] model(input logic [16*DW-1:0] d, input int unsigned idx);
      longint s;
      s = 0;
      for (int unsigned k = 0; k < NCH[idx]; k++) s += longint'($signed(d[k*DW +: DW]));
      s += longint'(BIASV[idx]);
      if (ACTV[idx] && s < 0) s = -((-s + 7) / 8);
      if (s > 32767) s = 32767;
      if (s < -32768) s = -32768;
      return DW'(s);
   endfunction

   logic [DW-1:0] sb[ND][$];
   int unsigned   ocnt  [ND];
   int unsigned   n_out [ND];
   int unsigned   n_last[ND];
   int unsigned   n_fd  [ND];
   logic          prev_last[ND];
   logic          held_v[ND];
   logic [DW-1:0] held_d[ND];
   logic          acc[ND];
   logic          armed      = 1'b0;
   logic          just_reset = 1'b0;

   // One cycle: drive inputs at the falling edge, sample 1 ns later, and
   // account for the handshakes that the next rising edge will perform.
   task automatic step(input logic rst_v, input logic vin_v,
                       input logic [16*DW-1:0] din_v, input logic rin_v);
      @(negedge Clk);
      Rst = rst_v; vin = vin_v; din = din_v; rin = rin_v;
      #1;
      for (int unsigned d = 0; d < ND; d++) begin
         acc[d] = 1'b0;
         if (armed) begin
            if (just_reset) check($sformatf("reset_valid_out[%0d]", d), 32'(vout[d]), 32'd0);
            check($sformatf("ready_out[%0d]", d), 32'(rout[d]), 32'(!(vout[d] && !rin_v)));
            check($sformatf("last_out[%0d]", d), 32'(lout[d]), 32'(vout[d] && ocnt[d] == FPIX[d] - 1));
            check($sformatf("frame_done[%0d]", d), 32'(fdone[d]), 32'(prev_last[d]));
            if (held_v[d]) begin
               check($sformatf("stall_valid[%0d]", d), 32'(vout[d]), 32'd1);
               check($sformatf("stall_data[%0d]", d), 32'(dout[d]), 32'(held_d[d]));
            end
         end
         if (!rst_v) begin
            sb[d].delete();
            ocnt[d] = 0; prev_last[d] = 1'b0; held_v[d] = 1'b0;
         end else begin
            n_last[d] += 32'(lout[d] && rin_v);
            n_fd[d]   += 32'(fdone[d]);
            prev_last[d] = vout[d] && rin_v && (ocnt[d] == FPIX[d] - 1);
            held_v[d] = vout[d] && !rin_v;
            held_d[d] = dout[d];
            if (vout[d] && rin_v) begin
               n_out[d]++;
               if (sb[d].size() == 0) check($sformatf("unexpected_output[%0d]", d), 32'd1, 32'd0);
               else check($sformatf("data_out[%0d]", d), 32'(dout[d]), 32'(sb[d].pop_front()));
               ocnt[d] = (ocnt[d] == FPIX[d] - 1) ? 0 : ocnt[d] + 1;
            end
            if (vin_v && rout[d]) begin
               sb[d].push_back(model(din_v, d));
               acc[d] = 1'b1;
            end
         end
      end
      if (!rst_v) armed = 1'b1;
      just_reset = !rst_v;
   endtask

   task automatic do_reset();
      step(1'b0, 1'b0, '0, 1'b1);
      step(1'b0, 1'b0, '0, 1'b1);
   endtask

   task automatic drain();
      for (int unsigned n = 0; n < 100; n++) begin
         int unsigned pending;
         pending = 0;
         for (int unsigned d = 0; d < ND; d++) pending += sb[d].size();
         if (pending == 0) break;
         step(1'b1, 1'b0, '0, 1'b1);
      end
      step(1'b1, 1'b0, '0, 1'b1);
      for (int unsigned d = 0; d < ND; d++)
         check($sformatf("drain_empty[%0d]", d), 32'(sb[d].size()), 32'd0);
   endtask

   function automatic logic [16*DW-1:0] rand_lanes();
      logic [16*DW-1:0] r;
      for (int unsigned k = 0; k < 16; k++) begin
         if ($urandom_range(0, 3) == 0) r[k*DW +: DW] = DW'($urandom);
         else r[k*DW +: DW] = DW'($urandom_range(0, 1023)) - DW'(512);
      end
      return r;
   endfunction

   typedef struct packed {
      logic [DW-1:0]          lane;
      logic [ND-1:0][DW-1:0]  exp;
   } vec_t;

   function automatic vec_t mk(input logic [DW-1:0] l, input logic [DW-1:0] e0, e1, e2, e3, e4);
      vec_t v;
      v.lane = l;
      v.exp  = {e4, e3, e2, e1, e0};
      return v;
   endfunction

   initial begin
      vec_t             vecs[7];
      logic [DW-1:0]    lane;
      logic [16*DW-1:0] d;
      int unsigned      b;
      int unsigned      cyc;
      int unsigned      base_out[ND];
      int unsigned      base_last, base_fd;

      //                lane      default   linear    bias=1.0  3 lanes   4x4 frame
      vecs[0] = mk(16'h0100, 16'h1000, 16'h1000, 16'h1100, 16'h0300, 16'h1000);
      vecs[1] = mk(16'hFF00, 16'hFE00, 16'hF000, 16'hFE20, 16'hFFA0, 16'hFE00);
      vecs[2] = mk(16'h7FFF, 16'h7FFF, 16'h7FFF, 16'h7FFF, 16'h7FFF, 16'h7FFF);
      vecs[3] = mk(16'h8000, 16'h8000, 16'h8000, 16'h8000, 16'hD000, 16'h8000);
      vecs[4] = mk(16'h0000, 16'h0000, 16'h0000, 16'h0100, 16'h0000, 16'h0000);
      vecs[5] = mk(16'h0001, 16'h0010, 16'h0010, 16'h0110, 16'h0003, 16'h0010);
      vecs[6] = mk(16'hFFFF, 16'hFFFE, 16'hFFF0, 16'h00F0, 16'hFFFF, 16'hFFFE);

      for (int unsigned d = 0; d < ND; d++) begin
         n_out[d] = 0; n_last[d] = 0; n_fd[d] = 0;
         ocnt[d] = 0; prev_last[d] = 1'b0; held_v[d] = 1'b0; acc[d] = 1'b0;
      end
      Rst = 1'b0; vin = 1'b0; din = '0; rin = 1'b1;

      // Single beats: exact latency and value per configuration.
      for (int unsigned v = 0; v < 7; v++) begin
         do_reset();
         lane = vecs[v].lane;
         step(1'b1, 1'b1, {16{lane}}, 1'b1);
         for (int unsigned n = 1; n <= 8; n++) begin
            step(1'b1, 1'b0, '0, 1'b1);
            for (int unsigned d = 0; d < ND; d++) begin
               check($sformatf("vec%0d_valid[%0d]@%0d", v, d, n), 32'(vout[d]), 32'(n == LAT[d]));
               if (n == LAT[d])
                  check($sformatf("vec%0d_data[%0d]", v, d), 32'(dout[d]), 32'(vecs[v].exp[d]));
            end
         end
         drain();
      end

      // Backpressure: 20 incrementing beats, ready_in low on cycles 8..12.
      do_reset();
      for (int unsigned dd = 0; dd < ND; dd++) base_out[dd] = n_out[dd];
      b = 0; cyc = 0;
      while (b < 20 && cyc < 200) begin
         for (int unsigned k = 0; k < 16; k++) d[k*DW +: DW] = DW'(b * 32 + k);
         step(1'b1, 1'b1, d, !(cyc >= 8 && cyc <= 12));
         if (cyc >= 8 && cyc <= 12) check($sformatf("bp_ready_low@%0d", cyc), 32'(rout[0]), 32'd0);
         if (acc[0]) b++;
         cyc++;
      end
      check("bp_beats_accepted", b, 32'd20);
      drain();
      for (int unsigned dd = 0; dd < ND; dd++)
         check($sformatf("bp_outputs[%0d]", dd), n_out[dd] - base_out[dd], 32'd20);

      // 4x4 frames: 40 back-to-back beats.
      do_reset();
      base_last = n_last[4]; base_fd = n_fd[4];
      b = 0; cyc = 0;
      while (b < 40 && cyc < 200) begin
         step(1'b1, 1'b1, rand_lanes(), 1'b1);
         if (acc[4]) b++;
         cyc++;
      end
      drain();
      check("frame_last_count", n_last[4] - base_last, 32'd2);
      check("frame_done_count", n_fd[4] - base_fd, 32'd2);
      check("frame_pix_count", 32'(u_img4.pix_count), 32'd8);

      // Reset mid-frame with three beats in flight and the output stalled.
      do_reset();
      for (int unsigned n = 0; n < 5; n++) step(1'b1, 1'b1, rand_lanes(), 1'b1);
      drain();
      for (int unsigned n = 0; n < 3; n++) step(1'b1, 1'b1, rand_lanes(), 1'b1);
      step(1'b1, 1'b0, '0, 1'b1);
      step(1'b1, 1'b0, '0, 1'b1);
      for (int unsigned n = 0; n < 4; n++) step(1'b1, 1'b0, '0, 1'b0);
      check("pre_reset_stalled_valid", 32'(vout[4]), 32'd1);
      check("pre_reset_ready_low", 32'(rout[4]), 32'd0);
      step(1'b0, 1'b0, '0, 1'b0);
      step(1'b1, 1'b0, '0, 1'b1);
      check("post_reset_ready", 32'(rout[4]), 32'd1);
      base_last = n_last[4];
      b = 0; cyc = 0;
      while (b < 20 && cyc < 200) begin
         step(1'b1, 1'b1, rand_lanes(), 1'b1);
         if (acc[4]) b++;
         cyc++;
      end
      drain();
      check("post_reset_last_count", n_last[4] - base_last, 32'd1);

      // Random traffic and backpressure against the reference model.
      do_reset();
      for (int unsigned n = 0; n < 800; n++)
         step(1'b1, $urandom_range(0, 9) < 7, rand_lanes(), $urandom_range(0, 3) != 0);
      drain();

      $display("== %0d vectors applied, %0d miscompares ==", applied, miscompares);
      $finish;
   end
endmodule

// File: doc/featuremap_channel_reducer.md
Name: featuremap_channel_reducer

Overview:
- Parametrised successor to the per-feature-map 3x3 convolution stage.
- Takes NUM_CH packed per-channel convolution partial results per pixel and reduces them through a registered adder tree to one output-feature-map pixel.
- Adds a per-map bias, saturates, applies optional leaky ReLU, and tags frame boundaries.
- Sits between the per-channel Conv2D3x3 bank and the next layer's line buffer. Supports downstream backpressure.

Parameters:
- NUM_CH, 16: input channels (lanes); any value ≥ 1; tree padded with zeros to next power of two.
- DATA_WIDTH, 16: signed two's-complement fixed-point lane and output width.
- FRAC_BITS, 8: fractional bits of DATA_WIDTH; informational, arithmetic is format-agnostic.
- IMG_SIZE, 208: output frame is IMG_SIZE x IMG_SIZE pixels.
- BIAS, 0: signed DATA_WIDTH bias, same Q format.
- ACT_EN, 1: 1 = leaky ReLU, 0 = linear.
- LEAKY_SHIFT, 3: negative slope = 2^-LEAKY_SHIFT, arithmetic right shift.

Ports:
- Clk  in  1  clock, rising edge.
- Rst  in  1  synchronous, active-low reset.
- data_in  in  NUM_CH*DATA_WIDTH  lane k at bits [k*DATA_WIDTH +: DATA_WIDTH].
- valid_in  in  1  data_in valid.
- ready_out  out  1  block can accept data_in this cycle.
- data_out  out  DATA_WIDTH  reduced, biased, activated pixel.
- valid_out  out  1  data_out valid.
- ready_in  in  1  downstream accepts data_out.
- last_out  out  1  data_out is final pixel of frame.
- frame_done  out  1  one-cycle pulse after final pixel handshake.

Behaviour:
- Reset (Rst=0 at a rising edge): all stage valids, valid_out, last_out and frame_done go to 0; data_out goes to 0; pixel counter goes to 0. Reset overrides everything, including a mid-frame or stalled state; in-flight data is discarded.
- Global enable: en = !(valid_out && !ready_in). ready_out = en, combinational.
- Input handshake: valid_in && ready_out.
- When en = 1, every pipeline stage advances, bubbles included. When en = 0, every stage holds.
- Tree: S = clog2(NUM_CH) registered stages (S = 0 when NUM_CH = 1). Stage i adds adjacent pairs.
- Accumulator width ACC_W = DATA_WIDTH + S + 1, sign-extended. No overflow is possible inside the tree.
- Post stage (registered):
  - add sign-extended BIAS;
  - if ACT_EN and the sum is negative, arithmetic shift right by LEAKY_SHIFT (floor, toward −inf);
  - saturate to [−2^(DATA_WIDTH−1), 2^(DATA_WIDTH−1)−1].
- Output stage: the post-stage result is registered into data_out and valid_out.
- Latency: LATENCY = S + 2 cycles from input handshake to valid_out, with no stalls. Default is 6.
- Throughput: one pixel per cycle while ready_in = 1.
- data_out is held stable while valid_out && !ready_in. data_out is don't-care when valid_out = 0; the bench checks it only when valid.
- Pixel counter: width clog2(IMG_SIZE*IMG_SIZE). Increments on output handshake (valid_out && ready_in).
- last_out = valid_out && (count == IMG_SIZE*IMG_SIZE−1), combinational from the counter.
- On the handshake of the last pixel, the counter wraps to 0 and frame_done pulses high on the next cycle.
- Back-to-back frames need no gap.
- Simultaneous stall-release and new input: the input is accepted in the same cycle the output handshakes.

Decomposition:
- Shared package holds:
  - clog2 function;
  - ACC_W and LATENCY derivation;
  - saturate function;
  - leaky-ReLU function.
- One sub-module, adder_tree_stage: parametrised pair-adder row with enable and valid, instantiated S times via generate.

Test Plan:
- Defaults, BIAS=0, all lanes 0x0100 (1.0), one beat → after 6 cycles data_out = 0x1000 (16.0), valid_out for one cycle.
- All lanes 0xFF00 (−1.0), ACT_EN=1 → data_out = 0xFE00 (−16 >>> 3 = −2.0). Same stimulus with ACT_EN=0 → 0xF000.
- Saturation:
  - all lanes 0x7FFF, BIAS=0x0100 → 0x7FFF;
  - all lanes 0x8000, ACT_EN=0 → 0x8000;
  - NUM_CH=3 with lanes 0x0100 → 0x0300 after LATENCY = 4.
- Backpressure: stream 20 beats of incrementing values, ready_in low for cycles 8–12 → ready_out low while stalled, no loss or duplication, output order preserved, data_out stable during the stall.
- IMG_SIZE=4: 40 back-to-back beats → last_out on outputs 16 and 32; frame_done pulses after each; counter = 8 at end.
- Reset: Rst low mid-frame with 3 beats in flight and valid_out stalled → next cycle valid_out = 0, ready_out = 1; the next frame's last_out occurs on its 16th output.
